// File: rtl/int_to_floating_point.sv
// Signed integer to IEEE-754 binary float converter. Normalizes one bit per cycle,
// then applies one of four rounding modes in a single rounding cycle.
module int_to_floating_point #(
    parameter int int_size      = 64,
    parameter int mantissa_size = 23,
    parameter int exponent_size = 8,
    parameter int precision     = 1 + exponent_size + mantissa_size,
    parameter int exp_bias      = (1 << (exponent_size - 1)) - 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [int_size-1:0]  int_operand,
    input  logic [1:0]           conv,
    output logic [precision-1:0] float,
    output logic                 inexact_flag,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           fsm_state
);

    // Handshake: start is sampled only in IDLE or DONE; the accepting edge captures
    // int_operand and conv, clears done and raises busy. done stays high with float and
    // inexact_flag held until the next accepted start; starts seen while busy are ignored.

    localparam int lz_w      = $clog2(int_size) + 1;
    localparam int guard_pos = int_size - 2 - mantissa_size;
    localparam logic [int_size-1:0] sticky_mask =
        {{(int_size - guard_pos){1'b0}}, {guard_pos{1'b1}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state;
    logic                    sign;
    logic [int_size-1:0]     mag;
    logic [1:0]              mode;
    logic [lz_w-1:0]         lz;

    logic [int_size-1:0]      mag_in;
    logic [mantissa_size-1:0] frac;
    logic                     guard;
    logic                     sticky;
    logic                     inc;
    logic [mantissa_size:0]   frac_sum;
    logic [exponent_size-1:0] exp_full;
    logic [exponent_size-1:0] exp_rounded;
    logic [precision-1:0]     result;

    assign fsm_state = state;

    // Magnitude as unsigned: the most negative value maps to 2^(int_size-1).
    assign mag_in = int_operand[int_size-1]
                  ? (~int_operand + {{(int_size-1){1'b0}}, 1'b1})
                  : int_operand;

    assign frac     = mag[int_size-2 -: mantissa_size];
    assign guard    = mag[guard_pos];
    assign sticky   = |(mag & sticky_mask);
    assign exp_full = exponent_size'(exp_bias + int_size - 1) - exponent_size'(lz);

    always_comb begin
        inc = 1'b0;
        case (mode)
            2'd0: inc = 1'b0;
            2'd1: inc = (guard | sticky) & ~sign;
            2'd2: inc = (guard | sticky) & sign;
            2'd3: inc = guard & (sticky | frac[0]);
            default: inc = 1'b0;
        endcase
    end

    // A carry out of the fraction leaves it all-zero and bumps the exponent.
    assign frac_sum    = {1'b0, frac} + {{mantissa_size{1'b0}}, inc};
    assign exp_rounded = exp_full + {{(exponent_size-1){1'b0}}, frac_sum[mantissa_size]};
    assign result      = {sign, exp_rounded, frac_sum[mantissa_size-1:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            sign         <= 1'b0;
            mag          <= '0;
            mode         <= 2'd0;
            lz           <= '0;
            float        <= '0;
            inexact_flag <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sign  <= int_operand[int_size-1];
                        mag   <= mag_in;
                        mode  <= conv;
                        lz    <= '0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        state <= NORM;
                    end
                end
                NORM: begin
                    if (mag == '0) begin
                        float        <= '0;
                        inexact_flag <= 1'b0;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        state        <= DONE;
                    end else if (mag[int_size-1]) begin
                        state <= ROUND;
                    end else begin
                        mag <= mag << 1;
                        lz  <= lz + {{(lz_w-1){1'b0}}, 1'b1};
                    end
                end
                ROUND: begin
                    float        <= result;
                    inexact_flag <= guard | sticky;
                    busy         <= 1'b0;
                    done         <= 1'b1;
                    state        <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_int_to_floating_point.sv
// Bench for int_to_floating_point (int64 -> binary32): table vectors, random vectors
// checked against an independent reference model, and hand-written corner sequences.
module tb_int_to_floating_point;

    localparam int W = 41;  // {float[31:0], inexact, latency[7:0]}

    logic        clk;
    logic        reset;
    logic        start;
    logic [63:0] int_operand;
    logic [1:0]  conv;
    logic [31:0] float;
    logic        inexact_flag;
    logic        busy;
    logic        done;
    logic [1:0]  fsm_state;

    logic [W-1:0] exp_q[$];
    int n_checks;
    int n_fail;

    typedef struct {
        logic [63:0] val;
        logic [1:0]  mode;
        logic [31:0] exp_f;
        logic        exp_x;
    } vec_t;

    vec_t vecs[11];

    int_to_floating_point dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .int_operand  (int_operand),
        .conv         (conv),
        .float        (float),
        .inexact_flag (inexact_flag),
        .busy         (busy),
        .done         (done),
        .fsm_state    (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no end expected end of test");
        $fatal(1, "global timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: locate the MSB, then round the discarded bits by comparison
    // against the half-ULP value.
    task automatic ref_conv(input logic [63:0] v, input logic [1:0] c,
                            output logic [31:0] f, output logic x, output int lat);
        logic        s;
        logic [63:0] m;
        logic [63:0] kept;
        logic [63:0] rem;
        logic [63:0] half;
        logic [7:0]  e;
        logic        up;
        int          p;
        int          sh;
        s = v[63];
        m = s ? (~v + 64'd1) : v;
        f = 32'd0;
        x = 1'b0;
        lat = 1;
        if (m != 64'd0) begin
            p = 0;
            for (int i = 0; i < 64; i++) if (m[i]) p = i;
            lat = (63 - p) + 2;
            e = 8'(127 + p);
            if (p <= 23) begin
                kept = m << (23 - p);
                x = 1'b0;
            end else begin
                sh   = p - 23;
                kept = m >> sh;
                rem  = m & ((64'd1 << sh) - 64'd1);
                half = 64'd1 << (sh - 1);
                x    = (rem != 64'd0);
                case (c)
                    2'd1:    up = x && !s;
                    2'd2:    up = x && s;
                    2'd3:    up = (rem > half) || (rem == half && kept[0]);
                    default: up = 1'b0;
                endcase
                kept = kept + {63'd0, up};
                if (kept == (64'd1 << 24)) begin
                    kept = kept >> 1;
                    e = e + 8'd1;
                end
            end
            f = {s, e, kept[22:0]};
        end
    endtask

    // driver: present start for one edge and confirm acceptance
    task automatic launch(input logic [63:0] v, input logic [1:0] c);
        @(negedge clk);
        int_operand = v;
        conv = c;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("accept_busy", {63'd0, busy}, 64'd1);
        check("accept_done", {63'd0, done}, 64'd0);
    endtask

    // Wait for done (bounded), then pop the scoreboard and compare. A start pulse with
    // different operands is injected at cycle glitch_at (negative disables it).
    task automatic wait_result(input string name, input int glitch_at);
        logic [W-1:0] e;
        int k;
        k = 0;
        while (!done && k < 200) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            k++;
            if (k == glitch_at && !done) begin
                int_operand = 64'hFFFF_FFFF_FFFF_FFFF;
                conv = 2'd2;
                start = 1'b1;
            end
        end
        start = 1'b0;
        e = exp_q.pop_front();
        if (!done) begin
            check({name, "_timeout"}, 64'd0, 64'd1);
        end else begin
            check({name, "_float"}, {32'd0, float}, {32'd0, e[40:9]});
            check({name, "_inexact"}, {63'd0, inexact_flag}, {63'd0, e[8]});
            check({name, "_latency"}, 64'(k), {56'd0, e[7:0]});
            check({name, "_busy_low"}, {63'd0, busy}, 64'd0);
        end
    endtask

    task automatic run_model(input string name, input logic [63:0] v, input logic [1:0] c);
        logic [31:0] f;
        logic        x;
        int          lat;
        ref_conv(v, c, f, x, lat);
        exp_q.push_back({f, x, 8'(lat)});
        launch(v, c);
        wait_result(name, -1);
    endtask

    initial begin
        logic [31:0] f;
        logic        x;
        int          lat;
        logic [63:0] v;
        logic [W-1:0] held;

        n_checks = 0;
        n_fail = 0;
        start = 1'b0;
        int_operand = 64'd0;
        conv = 2'd0;
        reset = 1'b0;

        vecs[0]  = '{64'd1,                    2'd0, 32'h3F80_0000, 1'b0};
        vecs[1]  = '{64'hFFFF_FFFF_FFFF_FFFF,  2'd0, 32'hBF80_0000, 1'b0};
        vecs[2]  = '{64'd0,                    2'd0, 32'h0000_0000, 1'b0};
        vecs[3]  = '{64'h8000_0000_0000_0000,  2'd0, 32'hDF00_0000, 1'b0};
        vecs[4]  = '{64'd16777217,             2'd3, 32'h4B80_0000, 1'b1};
        vecs[5]  = '{64'd16777217,             2'd1, 32'h4B80_0001, 1'b1};
        vecs[6]  = '{64'd16777219,             2'd3, 32'h4B80_0002, 1'b1};
        vecs[7]  = '{-64'sd16777217,           2'd2, 32'hCB80_0001, 1'b1};
        vecs[8]  = '{-64'sd16777217,           2'd0, 32'hCB80_0000, 1'b1};
        vecs[9]  = '{64'h7FFF_FFFF_FFFF_FFFF,  2'd0, 32'h5EFF_FFFF, 1'b1};
        vecs[10] = '{64'h7FFF_FFFF_FFFF_FFFF,  2'd3, 32'h5F00_0000, 1'b1};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_float", {32'd0, float}, 64'd0);
        check("rst_inexact", {63'd0, inexact_flag}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_state", {62'd0, fsm_state}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // table vectors, issued back-to-back so later ones are accepted from DONE
        for (int i = 0; i < 11; i++) begin
            ref_conv(vecs[i].val, vecs[i].mode, f, x, lat);
            exp_q.push_back({vecs[i].exp_f, vecs[i].exp_x, 8'(lat)});
            launch(vecs[i].val, vecs[i].mode);
            wait_result($sformatf("vec%0d", i), -1);
        end

        // start while busy is ignored; result stays held while done
        exp_q.push_back({32'h3F80_0000, 1'b0, 8'd65});
        launch(64'd1, 2'd0);
        wait_result("busy_ignore", 5);
        held = {32'h3F80_0000, 1'b0, 8'd65};
        repeat (3) @(posedge clk);
        #1;
        check("hold_float", {32'd0, float}, {32'd0, held[40:9]});
        check("hold_done", {63'd0, done}, 64'd1);

        // reset in the middle of normalization aborts asynchronously
        launch(64'd1, 2'd0);
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("abort_float", {32'd0, float}, 64'd0);
        check("abort_inexact", {63'd0, inexact_flag}, 64'd0);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_state", {62'd0, fsm_state}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("abort_idle_done", {63'd0, done}, 64'd0);
        check("abort_idle_busy", {63'd0, busy}, 64'd0);

        // conversion still works after the abort
        run_model("post_abort", 64'd12345, 2'd3);

        // random vectors over a spread of magnitudes and all modes
        for (int i = 0; i < 40; i++) begin
            v = {$urandom, $urandom} >> $urandom_range(0, 63);
            if ($urandom_range(0, 1) == 1) v = ~v + 64'd1;
            run_model($sformatf("rnd%0d", i), v, 2'($urandom_range(0, 3)));
        end

        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
